// File: rtl/sound_pkg.sv
// Shared sound types for the snake game audio path.
// Sound request encoding, mode, tone FSM states and event priority.
package sound_pkg;

   typedef enum logic [1:0] {
      SND_NONE = 2'd0,
      SND_MOVE = 2'd1,
      SND_GOOD = 2'd2,
      SND_BAD  = 2'd3
   } sound_type_t;

   typedef enum logic {
      OFF = 1'b0,
      ON  = 1'b1
   } mode_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      NOTE1 = 2'd1,
      GAP   = 2'd2,
      NOTE2 = 2'd3
   } tone_state_t;

   // Preemption rank: BAD > GOOD > MOVE > NONE.
   function automatic logic [1:0] prio(input sound_type_t t);
      unique case (1'b1)
         (t == SND_BAD):  prio = 2'd3;
         (t == SND_GOOD): prio = 2'd2;
         (t == SND_MOVE): prio = 2'd1;
         default:         prio = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: load starts high with a new half period.
// Ports: load, half_period, enable in; wave out (registered).
module tone_divider #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             nRst_i,
   input  logic             load,
   input  logic [CNT_W-1:0] half_period,
   input  logic             enable,
   output logic             wave
);

   logic [CNT_W-1:0] hp_cnt;
   logic [CNT_W-1:0] hp_reg;

   always_ff @(posedge clk or negedge nRst_i) begin
      if (!nRst_i) begin
         hp_cnt <= '0;
         hp_reg <= '0;
         wave   <= 1'b0;
      end else if (load) begin
         hp_reg <= half_period;
         hp_cnt <= half_period - CNT_W'(1);
         wave   <= 1'b1;
      end else if (enable) begin
         if (hp_cnt == '0) begin
            wave   <= ~wave;
            hp_cnt <= hp_reg - CNT_W'(1);
         end else begin
            hp_cnt <= hp_cnt - CNT_W'(1);
         end
      end else begin
         // Not sounding: pin parked low.
         wave   <= 1'b0;
         hp_cnt <= '0;
      end
   end

endmodule

// File: rtl/tone_player.sv
// Buzzer back end: turns one-cycle sound requests into tone sequences.
// Ports: playSound_i/soundType_i/mode_i in; speaker_o, busy_o, done_o out.
module tone_player
   import sound_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int HP_MOVE   = 2,
   parameter int HP_GOOD   = 4,
   parameter int HP_BAD_HI = 3,
   parameter int HP_BAD_LO = 6,
   parameter int NOTE_LEN  = 16,
   parameter int GAP_LEN   = 4
) (
   input  logic        clk,
   input  logic        nRst_i,
   input  logic        playSound_i,
   input  sound_type_t soundType_i,
   input  mode_t       mode_i,
   output logic        speaker_o,
   output logic        busy_o,
   output logic        done_o
);

   tone_state_t      state;
   sound_type_t      cur;
   logic [CNT_W-1:0] len_cnt;

   logic             on;
   logic             in_note;
   logic             muting;
   logic             take;
   logic             gap_end;
   logic             div_load;
   logic             div_en;
   logic [CNT_W-1:0] div_hp;

   function automatic logic [CNT_W-1:0] hp_of(input sound_type_t t);
      unique case (1'b1)
         (t == SND_GOOD): hp_of = CNT_W'(HP_GOOD);
         (t == SND_BAD):  hp_of = CNT_W'(HP_BAD_HI);
         default:         hp_of = CNT_W'(HP_MOVE);
      endcase
   endfunction

   always_comb begin
      on      = (mode_i == ON);
      in_note = (state == NOTE1) || (state == NOTE2);
      muting  = (state != IDLE) && !on;
      // From IDLE any real sound starts; while busy only a higher rank.
      take    = playSound_i && on &&
                ((state == IDLE) ? (soundType_i != SND_NONE)
                                 : (prio(soundType_i) > prio(cur)));
      gap_end = (state == GAP) && (len_cnt == '0);
      div_load = take || (gap_end && on);
      div_hp   = take ? hp_of(soundType_i) : CNT_W'(HP_BAD_LO);
      // Last note cycle disables the divider so the pin drops low.
      div_en   = in_note && on && (len_cnt != '0);
   end

   tone_divider #(
      .CNT_W(CNT_W)
   ) u_div (
      .clk        (clk),
      .nRst_i     (nRst_i),
      .load       (div_load),
      .half_period(div_hp),
      .enable     (div_en),
      .wave       (speaker_o)
   );

   always_ff @(posedge clk or negedge nRst_i) begin
      if (!nRst_i) begin
         state   <= IDLE;
         cur     <= SND_NONE;
         len_cnt <= '0;
         done_o  <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (muting) begin
            state   <= IDLE;
            len_cnt <= '0;
         end else if (take) begin
            state   <= NOTE1;
            cur     <= soundType_i;
            len_cnt <= CNT_W'(NOTE_LEN - 1);
         end else begin
            unique case (state)
               IDLE: ;
               NOTE1, NOTE2: begin
                  if (len_cnt == '0) begin
                     if (state == NOTE1 && cur == SND_BAD) begin
                        state   <= GAP;
                        len_cnt <= CNT_W'(GAP_LEN - 1);
                     end else begin
                        state  <= IDLE;
                        done_o <= 1'b1;
                     end
                  end else begin
                     len_cnt <= len_cnt - CNT_W'(1);
                  end
               end
               GAP: begin
                  if (len_cnt == '0) begin
                     state   <= NOTE2;
                     len_cnt <= CNT_W'(NOTE_LEN - 1);
                  end else begin
                     len_cnt <= len_cnt - CNT_W'(1);
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player.
// Vector table, hand sequences and random stimulus vs a timeline model.
module tb_tone_player;
   import sound_pkg::*;

   logic        tb_clk = 1'b0;
   logic        nRst_i;
   logic        playSound_i;
   sound_type_t soundType_i;
   mode_t       mode_i;
   logic        speaker_o;
   logic        busy_o;
   logic        done_o;

   int errs   = 0;
   int checks = 0;

   always #5 tb_clk = ~tb_clk;

   tone_player dut (
      .clk        (tb_clk),
      .nRst_i     (nRst_i),
      .playSound_i(playSound_i),
      .soundType_i(soundType_i),
      .mode_i     (mode_i),
      .speaker_o  (speaker_o),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   // Model: active sequence type and cycles since its start.
   bit          m_act;
   sound_type_t m_typ;
   int          m_t;
   bit          m_done;

   function automatic int rank(sound_type_t t);
      case (t)
         SND_BAD:  return 3;
         SND_GOOD: return 2;
         SND_MOVE: return 1;
         default:  return 0;
      endcase
   endfunction

   function automatic int total(sound_type_t t);
      return (t == SND_BAD) ? 36 : 16;
   endfunction

   function automatic bit wave(sound_type_t t, int k);
      if (t == SND_BAD) begin
         if (k < 16) return ((k / 3) % 2) == 0;
         if (k < 20) return 1'b0;
         return (((k - 20) / 6) % 2) == 0;
      end
      if (t == SND_GOOD) return ((k / 4) % 2) == 0;
      return ((k / 2) % 2) == 0;
   endfunction

   task automatic model_step(input bit ps, input sound_type_t ty,
                             input mode_t md);
      m_done = 1'b0;
      if (m_act && md == OFF) begin
         m_act = 1'b0;
      end else if (ps && md == ON &&
                   (m_act ? rank(ty) > rank(m_typ) : ty != SND_NONE)) begin
         m_act = 1'b1;
         m_typ = ty;
         m_t   = 0;
      end else if (m_act) begin
         m_t++;
         if (m_t == total(m_typ)) begin
            m_act  = 1'b0;
            m_done = 1'b1;
         end
      end
   endtask

   task automatic chk(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, edge, update model, compare.
   task automatic cyc(input bit ps, input sound_type_t ty, input mode_t md);
      playSound_i = ps;
      soundType_i = ty;
      mode_i      = md;
      @(posedge tb_clk);
      model_step(ps, ty, md);
      #1;
      chk("spk", speaker_o, m_act ? wave(m_typ, m_t) : 1'b0);
      chk("busy", busy_o, m_act);
      chk("done", done_o, m_done);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, SND_NONE, ON);
   endtask

   // Idle until sequence ends; counts busy and done cycles (bounded).
   task automatic run_out(output int nb, output int nd);
      nb = 0;
      nd = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, SND_NONE, ON);
         if (busy_o) nb++;
         if (done_o) nd++;
         if (!busy_o && !done_o) break;
      end
      chk("run_out_ends", busy_o, 1'b0);
   endtask

   typedef struct {
      bit          ps;
      sound_type_t ty;
      mode_t       md;
      logic        spk;
      logic        busy;
      logic        done;
   } vec_t;

   function automatic vec_t mk(bit ps, sound_type_t ty, mode_t md,
                               logic s, logic b, logic d);
      vec_t v;
      v.ps = ps; v.ty = ty; v.md = md;
      v.spk = s; v.busy = b; v.done = d;
      return v;
   endfunction

   vec_t tbl[20];

   initial begin
      int nb, nd;

      tbl[0]  = mk(1, SND_GOOD, ON, 1, 1, 0);
      tbl[1]  = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[2]  = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[3]  = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[4]  = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[5]  = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[6]  = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[7]  = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[8]  = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[9]  = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[10] = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[11] = mk(0, SND_NONE, ON, 1, 1, 0);
      tbl[12] = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[13] = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[14] = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[15] = mk(0, SND_NONE, ON, 0, 1, 0);
      tbl[16] = mk(0, SND_NONE, ON, 0, 0, 1);
      tbl[17] = mk(0, SND_NONE, ON, 0, 0, 0);
      tbl[18] = mk(1, SND_GOOD, OFF, 0, 0, 0);
      tbl[19] = mk(1, SND_NONE, ON, 0, 0, 0);

      m_act = 1'b0; m_typ = SND_NONE; m_t = 0; m_done = 1'b0;
      nRst_i = 1'b0;
      playSound_i = 1'b0;
      soundType_i = SND_NONE;
      mode_i = ON;
      repeat (2) @(posedge tb_clk);
      #1;
      chk("rst_spk", speaker_o, 1'b0);
      chk("rst_busy", busy_o, 1'b0);
      chk("rst_done", done_o, 1'b0);
      #2 nRst_i = 1'b1;
      idle(2);

      // Reset asserted mid-note, between edges.
      cyc(1'b1, SND_GOOD, ON);
      idle(2);
      #2 nRst_i = 1'b0;
      m_act = 1'b0; m_done = 1'b0;
      #1;
      chk("arst_spk", speaker_o, 1'b0);
      chk("arst_busy", busy_o, 1'b0);
      chk("arst_done", done_o, 1'b0);
      repeat (2) @(posedge tb_clk);
      #1;
      chk("hrst_spk", speaker_o, 1'b0);
      chk("hrst_busy", busy_o, 1'b0);
      #2 nRst_i = 1'b1;
      idle(2);

      // Vector table: GOOD note, muted request, NONE request.
      for (int i = 0; i < 20; i++) begin
         cyc(tbl[i].ps, tbl[i].ty, tbl[i].md);
         chk($sformatf("tbl%0d_spk", i), speaker_o, tbl[i].spk);
         chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
         chk($sformatf("tbl%0d_done", i), done_o, tbl[i].done);
      end

      // BAD: 36 busy cycles, one done.
      cyc(1'b1, SND_BAD, ON);
      run_out(nb, nd);
      chk_int("bad_busy", nb + 1, 36);
      chk_int("bad_done", nd, 1);

      // MOVE preempted by GOOD; later MOVE dropped.
      cyc(1'b1, SND_MOVE, ON);
      idle(4);
      cyc(1'b1, SND_GOOD, ON);
      idle(3);
      cyc(1'b1, SND_MOVE, ON);
      run_out(nb, nd);
      chk_int("pre_busy", nb + 5, 16);
      chk_int("pre_done", nd, 1);

      // Mute in BAD gap.
      cyc(1'b1, SND_BAD, ON);
      idle(17);
      chk("gap_busy", busy_o, 1'b1);
      cyc(1'b0, SND_NONE, OFF);
      chk("mute_busy", busy_o, 1'b0);
      chk("mute_spk", speaker_o, 1'b0);
      run_out(nb, nd);
      chk_int("mute_done", nd, 0);
      cyc(1'b1, SND_BAD, OFF);
      chk("off_req_busy", busy_o, 1'b0);

      // NONE ignored; GOOD on the done cycle accepted.
      cyc(1'b1, SND_NONE, ON);
      chk("none_busy", busy_o, 1'b0);
      cyc(1'b1, SND_GOOD, ON);
      idle(16);
      chk("b2b_done", done_o, 1'b1);
      cyc(1'b1, SND_GOOD, ON);
      chk("b2b_busy", busy_o, 1'b1);
      run_out(nb, nd);
      chk_int("b2b_len", nb + 1, 16);

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc($urandom_range(0, 7) == 0,
             sound_type_t'($urandom_range(0, 3)),
             ($urandom_range(0, 39) == 0) ? OFF : ON);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/tone_player.md
# tone_player

Audio back end for the snake game: consumes the one-cycle sound requests produced by the sound generator (`playSound` plus event type and the ON/OFF mode) and drives a square-wave speaker pin with a per-event tone sequence. It sits between the sound FSM and the board buzzer pad. It is busy for the duration of a note, applies preemption priority between events, and honours mute immediately.

## Interface
Parameters:
- CNT_W, 16, width of half-period and length counters
- HP_MOVE, 2, half-period in clk cycles, move tone
- HP_GOOD, 4, half-period, good-collision tone
- HP_BAD_HI, 3, half-period, first bad-collision note
- HP_BAD_LO, 6, half-period, second bad-collision note
- NOTE_LEN, 16, note length in clk cycles (all notes)
- GAP_LEN, 4, silent cycles between the two bad-collision notes

Ports:
- Clock and reset: one clock, `clk`; reset `nRst_i`, asynchronous, active-low.
- clk, in, 1, system clock
- nRst_i, in, 1, asynchronous active-low reset
- playSound_i, in, 1, one-cycle request strobe
- soundType_i, in, 2, sound_type_t, sampled only with playSound_i
- mode_i, in, 1, mode_t: OFF=0 mutes, ON=1 enables
- speaker_o, out, 1, registered square wave to the buzzer
- busy_o, out, 1, high whenever state != IDLE
- done_o, out, 1, one-cycle pulse on natural completion of a sequence

## Operation
- States: IDLE, NOTE1, GAP, NOTE2.
- Reset: state=IDLE, speaker_o=0, busy_o=0, done_o=0, all counters 0.
- Accept: on a clk edge with playSound_i=1, mode_i=ON and an accepted type, load type, set speaker_o<=1, hp_cnt<=HP-1 and len_cnt<=NOTE_LEN-1, then go to NOTE1.
- HP per type: MOVE=HP_MOVE, GOOD=HP_GOOD, BAD=HP_BAD_HI.
- SND_NONE requests are ignored.
- In NOTE1/NOTE2, each cycle:
  - hp_cnt==0: toggle speaker_o and reload HP-1; otherwise decrement.
  - len_cnt decrements every cycle.
- End of note (len_cnt==0 in NOTE1/NOTE2):
  - speaker_o<=0.
  - NOTE1 with BAD: go to GAP, len_cnt<=GAP_LEN-1.
  - Otherwise: go to IDLE and pulse done_o.
- GAP: speaker_o held 0. At len_cnt==0 go to NOTE2 with HP_BAD_LO, speaker_o<=1, len_cnt<=NOTE_LEN-1.
- Preemption while busy: priority BAD > GOOD > MOVE.
  - A strictly higher-priority request restarts at NOTE1 with the same load as Accept. No done_o for the aborted sequence.
  - An equal or lower-priority request is dropped.
- Mute: mode_i=OFF in any non-IDLE state forces IDLE and speaker_o<=0 on the next edge. No done_o.
- playSound_i is ignored while mode_i=OFF.

## Timing
- Latency: request at edge N gives speaker_o=1 and busy_o=1 after edge N.
- First toggle low occurs after edge N+HP.
- Single note: busy_o high for exactly NOTE_LEN cycles, and done_o is high in the cycle after busy_o falls.
- BAD sequence: busy for 2*NOTE_LEN+GAP_LEN cycles.
- Mute takes effect in 1 cycle.
- Reset mid-note: asynchronous return to the reset values above.

## Structure
- Shared `sound_pkg`, also used by the sound generator:
  - sound_type_t {SND_NONE=0, SND_MOVE=1, SND_GOOD=2, SND_BAD=3}
  - mode_t {OFF=0, ON=1}
  - tone_state_t
  - a priority function on sound_type_t
- One sub-module, `tone_divider`:
  - Contains the hp_cnt counter and the toggle logic.
  - Inputs: load, half_period, enable.
  - Output: the square wave.
  - The FSM instantiates it once.

## Test plan
All scenarios use default parameters.
- Reset with nRst_i=0 mid-clock: speaker_o=0, busy_o=0, done_o=0. Values hold across 2 edges and after release.
- GOOD request, mode ON: speaker_o reads 1,1,1,1,0,0,0,0,1… (HP 4). busy_o is high for 16 cycles, done_o pulses once, then speaker_o=0.
- BAD request: 16 cycles at HP 3, then 4 cycles low, then 16 cycles at HP 6. busy_o is high for 36 cycles, with one done_o.
- MOVE request, then GOOD 5 cycles later: GOOD restarts with HP 4 and a fresh 16-cycle length, and only one done_o occurs. A subsequent MOVE during GOOD is dropped.
- mode_i=OFF during the BAD GAP: next edge gives IDLE, speaker_o=0, no done_o. A request with mode OFF produces busy_o=0.
- SND_NONE request: no state change. Back-to-back GOOD on the cycle done_o pulses is accepted.
